// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : counter_checker
//  Purpose  : Monitors a free-running up-counter bus. Every clock it samples
//             q_in and checks that it equals the previous sample plus one,
//             modulo 2^WIDTH. After LOCK_CNT consecutive correct increments
//             the checker is LOCKED. Any break while LOCKED pulses err,
//             records the offending value and bumps a saturating error count.
//  Ports    :
//    clk      in   1      system clock, rising edge active
//    rst      in   1      asynchronous reset, active low
//    q_in     in   WIDTH  counter value under test
//    clr      in   1      synchronous clear of err_cnt and bad_val
//    locked   out  1      high while in LOCKED
//    err      out  1      one-cycle pulse per sequence break in LOCKED
//    err_cnt  out  ERR_W  saturating count of err pulses
//    bad_val  out  WIDTH  q_in value that caused the most recent err
//  Revision : 1.0  initial release
// ============================================================================
module counter_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,   // legal range 1..255
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] bad_val
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Run-length target compared at 9 bits so LOCK_CNT = 255 cannot overflow.
  localparam logic [8:0] LOCK_TGT = 9'(LOCK_CNT);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev;
  logic [7:0]       match_cnt, match_cnt_n;
  logic             err_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic [WIDTH-1:0] bad_val_n;
  logic [WIDTH-1:0] prev_inc;
  logic             match;

  // Increment at WIDTH bits so all-ones is legitimately followed by zero.
  assign prev_inc = prev + WIDTH'(1);
  assign match    = (q_in == prev_inc);

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      prev      <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      bad_val   <= '0;
    end else begin
      state     <= state_n;
      prev      <= q_in;
      match_cnt <= match_cnt_n;
      locked    <= (state_n == S_LOCKED);
      err       <= err_n;
      err_cnt   <= err_cnt_n;
      bad_val   <= bad_val_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    err_n       = 1'b0;
    err_cnt_n   = err_cnt;
    bad_val_n   = bad_val;

    case (state)
      S_IDLE: begin
        // First sample only seeds prev; nothing to compare against yet.
        state_n     = S_ACQ;
        match_cnt_n = '0;
      end

      S_ACQ: begin
        if (match) begin
          if (({1'b0, match_cnt} + 9'd1) == LOCK_TGT) begin
            state_n     = S_LOCKED;
            match_cnt_n = '0;
          end else begin
            match_cnt_n = match_cnt + 8'd1;
          end
        end else begin
          match_cnt_n = '0;
        end
      end

      S_LOCKED: begin
        if (!match) begin
          err_n       = 1'b1;
          bad_val_n   = q_in;
          state_n     = S_ACQ;
          match_cnt_n = '0;
          if (err_cnt != {ERR_W{1'b1}}) begin
            err_cnt_n = err_cnt + ERR_W'(1);
          end
        end
      end

      default: begin
        state_n     = S_IDLE;
        match_cnt_n = '0;
      end
    endcase

    // Clear overrides a coincident error for the count and captured value;
    // the err pulse and state change still happen.
    if (clr) begin
      err_cnt_n = '0;
      bad_val_n = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_checker
//  Purpose  : Directed self-checking bench for counter_checker
//             (WIDTH=8, LOCK_CNT=4, ERR_W=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_checker;

  logic       clk;
  logic       rst;
  logic [7:0] q_in;
  logic       clr;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] bad_val;

  int errors = 0;
  int checks = 0;

  counter_checker #(
    .WIDTH    (8),
    .LOCK_CNT (4),
    .ERR_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .bad_val (bad_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, let one rising edge take it, then settle 1 ns.
  task automatic step(input logic [7:0] v, input logic c);
    q_in = v;
    clr  = c;
    @(posedge clk);
    #1;
    clr  = 1'b0;
  endtask

  // Four correct increments after a break bring the checker back to LOCKED.
  task automatic relock(inout logic [7:0] v);
    for (int k = 0; k < 4; k++) begin
      v = v + 8'd1;
      step(v, 1'b0);
    end
    check("relock", 32'(locked), 32'd1);
  endtask

  logic [7:0] v;
  logic [7:0] exp_cnt;

  initial begin
    rst  = 1'b0;
    q_in = 8'd0;
    clr  = 1'b0;

    // ---- Reset and lock ----
    #12;
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_bad_val", 32'(bad_val), 32'd0);
    #8;
    rst = 1'b1;                         // released at 20 ns, between edges
    for (int i = 0; i < 4; i++) begin
      step(8'(i), 1'b0);
      check("acq_locked", 32'(locked), 32'd0);
      check("acq_err",    32'(err),    32'd0);
    end
    step(8'd4, 1'b0);
    check("lock_after_4", 32'(locked), 32'd1);
    check("lock_err",     32'(err),    32'd0);

    // ---- Wrap-around (walk up to 255, then 0,1,2) ----
    for (int i = 5; i <= 258; i++) begin
      step(8'(i), 1'b0);
      if (i >= 250) begin
        check("wrap_locked",  32'(locked),  32'd1);
        check("wrap_err",     32'(err),     32'd0);
        check("wrap_err_cnt", 32'(err_cnt), 32'd0);
      end
    end

    // ---- Sequence break: ...,10,11,13,14,15,16,17 ----
    for (int i = 3; i <= 11; i++) step(8'(i), 1'b0);
    check("pre_break_locked", 32'(locked), 32'd1);
    step(8'd13, 1'b0);
    check("brk_err",     32'(err),     32'd1);
    check("brk_err_cnt", 32'(err_cnt), 32'd1);
    check("brk_bad_val", 32'(bad_val), 32'd13);
    check("brk_locked",  32'(locked),  32'd0);
    step(8'd14, 1'b0);
    check("brk_err_once", 32'(err),    32'd0);
    check("brk_acq",      32'(locked), 32'd0);
    step(8'd15, 1'b0);
    step(8'd16, 1'b0);
    check("brk_not_yet", 32'(locked), 32'd0);
    step(8'd17, 1'b0);
    check("brk_relock",  32'(locked), 32'd1);

    // ---- Saturation: 300 more breaks ----
    v       = 8'd17;
    exp_cnt = 8'd1;
    for (int n = 0; n < 300; n++) begin
      v = v + 8'd2;                     // skip one value -> mismatch
      step(v, 1'b0);
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      check("sat_err",     32'(err),     32'd1);
      check("sat_bad_val", 32'(bad_val), 32'(v));
      check("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));
      relock(v);
    end
    check("sat_final", 32'(err_cnt), 32'd255);

    // ---- clr colliding with a mismatch ----
    v = v + 8'd5;
    step(v, 1'b1);
    check("clr_err",     32'(err),     32'd1);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_bad_val", 32'(bad_val), 32'd0);
    check("clr_locked",  32'(locked),  32'd0);
    relock(v);

    // ---- Build err_cnt = 3, then async reset mid-lock ----
    for (int n = 0; n < 3; n++) begin
      v = v + 8'd3;
      step(v, 1'b0);
      relock(v);
    end
    check("pre_rst_err_cnt", 32'(err_cnt), 32'd3);
    check("pre_rst_bad_val", 32'(bad_val), 32'(v - 8'd4));
    #2;
    rst = 1'b0;                         // between edges
    #1;
    check("arst_locked",  32'(locked),  32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_bad_val", 32'(bad_val), 32'd0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'(100 + i), 1'b0);
      check("arst_acq", 32'(locked), 32'd0);
    end
    step(8'd104, 1'b0);
    check("arst_relock_5", 32'(locked), 32'd1);

    // ---- Constant counter stays in ACQ with no err ----
    step(8'd50, 1'b0);
    check("const_brk_err", 32'(err), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(8'd50, 1'b0);
      check("const_err",    32'(err),    32'd0);
      check("const_locked", 32'(locked), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
